// File: rtl/frame_config_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_config_loader_pkg
// Purpose  : Shared state encodings, control words and header field layout
//            for the frame configuration loader.
// Revision : 1.0
// ============================================================================
package frame_config_loader_pkg;

  localparam logic [2:0] HUNT   = 3'd0;
  localparam logic [2:0] HEADER = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] SETUP  = 3'd3;
  localparam logic [2:0] STROBE = 3'd4;
  localparam logic [2:0] HOLD   = 3'd5;
  localparam logic [2:0] CHECK  = 3'd6;

  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;
  localparam logic [3:0]  HDR_MARKER  = 4'hA;

  localparam int HDR_MARKER_MSB = 31;
  localparam int HDR_MARKER_LSB = 28;
  localparam int HDR_LEN_MSB    = 23;
  localparam int HDR_LEN_LSB    = 16;
  localparam int HDR_IDX_MSB    = 7;
  localparam int HDR_IDX_LSB    = 0;

endpackage
`default_nettype wire

// File: rtl/frame_config_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_config_loader_if
// Purpose  : Valid/ready configuration word stream into the frame loader.
// Revision : 1.0
// ============================================================================
interface frame_config_loader_if;

  logic [31:0] WriteData;
  logic        WriteValid;
  logic        WriteReady;

  modport master (output WriteData, output WriteValid, input WriteReady);
  modport slave  (input WriteData, input WriteValid, output WriteReady);

endinterface
`default_nettype wire

// File: rtl/frame_config_loader_strobe_decoder.sv
`default_nettype none
// ============================================================================
// Module   : frame_strobe_decoder
// Purpose  : One-hot frame strobe decode with out-of-range detection.
// Revision : 1.0
// ============================================================================
module frame_strobe_decoder #(
  parameter int MaxFramesPerCol = 32,
  parameter int IDX_W           = 9
) (
  input  logic [IDX_W-1:0]           index,
  input  logic                       enable,
  output logic [MaxFramesPerCol-1:0] oneHot,
  output logic                       outOfRange
);

  localparam logic [IDX_W:0] c_MaxFrames = (IDX_W+1)'(MaxFramesPerCol);

  assign outOfRange = {1'b0, index} >= c_MaxFrames;

  generate
    for (genvar i = 0; i < MaxFramesPerCol; i++) begin : g_bit
      assign oneHot[i] = enable && !outOfRange && (index == IDX_W'(i));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/frame_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : frame_config_loader
// Purpose  : Sync/header decode of the config word stream; drives FrameData
//            and spaced one-hot FrameStrobe pulses. Optional burst checksum
//            word enabled by FRAME_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module frame_config_loader
  import frame_config_loader_pkg::*;
#(
  parameter int MaxFramesPerCol = 32,
  parameter int FrameBitsPerRow = 32,
  parameter int StrobeCycles    = 2
) (
  input  logic                       CLK,
  input  logic                       reset,
  frame_config_loader_if.slave       writeIf,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       Busy,
  output logic                       Error
);

  localparam int c_IdxW = 9;
  localparam int c_CntW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;

  logic [2:0]                 r_state;
  logic [2:0]                 w_nextState;
  logic                       r_started;
  logic [c_IdxW-1:0]          r_curIndex;
  logic [8:0]                 r_remaining;
  logic [c_CntW-1:0]          r_strobeCnt;
  logic [FrameBitsPerRow-1:0] r_frameData;
  logic [MaxFramesPerCol-1:0] r_frameStrobe;
  logic                       r_error;
`ifdef FRAME_CHECKSUM_EN
  logic [31:0]                r_xor;
`endif

  logic                       w_accept;
  logic                       w_isSync;
  logic                       w_isDesync;
  logic                       w_isHeader;
  logic                       w_strobeEn;
  logic                       w_outOfRange;
  logic [MaxFramesPerCol-1:0] w_decoded;

  assign w_accept   = writeIf.WriteValid && writeIf.WriteReady;
  assign w_isSync   = writeIf.WriteData == SYNC_WORD;
  assign w_isDesync = writeIf.WriteData == DESYNC_WORD;
  assign w_isHeader = writeIf.WriteData[HDR_MARKER_MSB:HDR_MARKER_LSB] == HDR_MARKER;

`ifdef FRAME_CHECKSUM_EN
  assign writeIf.WriteReady = r_started && (r_state inside {HUNT, HEADER, DATA, CHECK});
`else
  assign writeIf.WriteReady = r_started && (r_state inside {HUNT, HEADER, DATA});
`endif

  assign FrameData   = r_frameData;
  assign FrameStrobe = r_frameStrobe;
  assign Busy        = r_state != HUNT;
  assign Error       = r_error;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      HUNT:   if (w_accept && w_isSync) w_nextState = HEADER;
      HEADER: if (w_accept) w_nextState = (!w_isDesync && w_isHeader) ? DATA : HUNT;
      DATA:   if (w_accept) w_nextState = w_isDesync ? HUNT : SETUP;
      SETUP:  w_nextState = STROBE;
      STROBE: if (r_strobeCnt == '0) w_nextState = HOLD;
      HOLD: begin
        if (r_remaining != 9'd1) w_nextState = DATA;
`ifdef FRAME_CHECKSUM_EN
        else w_nextState = CHECK;
`else
        else w_nextState = HEADER;
`endif
      end
`ifdef FRAME_CHECKSUM_EN
      CHECK:  if (w_accept) w_nextState = HEADER;
`endif
      default: w_nextState = HUNT;
    endcase
  end

  // Strobe is registered from the next state so the latch enables are glitch-free
  assign w_strobeEn = w_nextState == STROBE;

  frame_strobe_decoder #(
    .MaxFramesPerCol(MaxFramesPerCol),
    .IDX_W          (c_IdxW)
  ) u_strobeDecoder (
    .index     (r_curIndex),
    .enable    (w_strobeEn),
    .oneHot    (w_decoded),
    .outOfRange(w_outOfRange)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state       <= HUNT;
      r_started     <= 1'b0;
      r_curIndex    <= '0;
      r_remaining   <= '0;
      r_strobeCnt   <= '0;
      r_frameData   <= '0;
      r_frameStrobe <= '0;
      r_error       <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_xor         <= '0;
`endif
    end else begin
      r_state       <= w_nextState;
      r_started     <= 1'b1;
      r_frameStrobe <= w_decoded;
      case (r_state)
        HUNT: if (w_accept && w_isSync) r_error <= 1'b0;
        HEADER: begin
          if (w_accept && !w_isDesync) begin
            if (w_isHeader) begin
              r_curIndex  <= {1'b0, writeIf.WriteData[HDR_IDX_MSB:HDR_IDX_LSB]};
              r_remaining <= {1'b0, writeIf.WriteData[HDR_LEN_MSB:HDR_LEN_LSB]} + 9'd1;
`ifdef FRAME_CHECKSUM_EN
              r_xor       <= '0;
`endif
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        DATA: begin
          if (w_accept && !w_isDesync) begin
            r_frameData <= writeIf.WriteData[FrameBitsPerRow-1:0];
`ifdef FRAME_CHECKSUM_EN
            r_xor       <= r_xor ^ writeIf.WriteData;
`endif
          end
        end
        SETUP: begin
          r_strobeCnt <= c_CntW'(StrobeCycles - 1);
          if (w_outOfRange) r_error <= 1'b1;
        end
        STROBE: if (r_strobeCnt != '0) r_strobeCnt <= r_strobeCnt - 1'b1;
        HOLD: begin
          r_curIndex  <= r_curIndex + 1'b1;
          r_remaining <= r_remaining - 1'b1;
        end
`ifdef FRAME_CHECKSUM_EN
        CHECK: if (w_accept && writeIf.WriteData != r_xor) r_error <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_config_loader
// Purpose  : Directed and randomized self-checking bench for the loader.
// Revision : 1.0
// ============================================================================
module tb_frame_config_loader;
  import frame_config_loader_pkg::*;

  localparam int MF = 32;
  localparam int FB = 32;
  localparam int SC = 2;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic [FB-1:0] FrameData;
  logic [MF-1:0] FrameStrobe;
  logic          Busy;
  logic          Error;

  frame_config_loader_if wif ();

  frame_config_loader #(
    .MaxFramesPerCol(MF),
    .FrameBitsPerRow(FB),
    .StrobeCycles   (SC)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .writeIf    (wif),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .Busy       (Busy),
    .Error      (Error)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          len;
    bit          setupOk;
    bit          holdOk;
  } ev_t;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  ev_t         evQ[$];
  ev_t         curEv;
  int          multiHot;
  int          jumps;
  int          sameEdge;
  logic [MF-1:0] prevStrobe;
  logic [FB-1:0] prevData;

  exp_t        expQ[$];
  bit          expErr;
  bit          expBusy;
  logic [31:0] stimQ[$];

  // Observed strobe pulses: index, data, width and data stability around them
  always @(negedge CLK) begin
    if (!reset) begin
      if ($countones(FrameStrobe) > 1) multiHot++;
      if (FrameStrobe != prevStrobe && FrameData != prevData) sameEdge++;
      if (prevStrobe == '0 && FrameStrobe != '0) begin
        for (int i = 0; i < MF; i++) if (FrameStrobe[i]) curEv.idx = i;
        curEv.data    = FrameData;
        curEv.len     = 1;
        curEv.setupOk = (prevData == FrameData);
        curEv.holdOk  = 1'b0;
      end else if (prevStrobe != '0 && FrameStrobe == prevStrobe) begin
        curEv.len++;
        if (FrameData != curEv.data) curEv.setupOk = 1'b0;
      end else if (prevStrobe != '0 && FrameStrobe == '0) begin
        curEv.holdOk = (FrameData == curEv.data);
        evQ.push_back(curEv);
      end else if (prevStrobe != '0 && FrameStrobe != '0) begin
        jumps++;
      end
    end
    prevStrobe = FrameStrobe;
    prevData   = FrameData;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clearMon();
    evQ.delete();
    multiHot = 0;
    jumps    = 0;
    sameEdge = 0;
  endtask

  task automatic doReset();
    reset          = 1'b1;
    wif.WriteValid = 1'b0;
    repeat (3) @(posedge CLK);
    #1 reset = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input int gap);
    int n;
    repeat (gap) begin
      @(negedge CLK);
      wif.WriteValid = 1'b0;
      wif.WriteData  = $urandom();
    end
    @(negedge CLK);
    wif.WriteData  = w;
    wif.WriteValid = 1'b1;
    n = 0;
    while (!wif.WriteReady && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 50) begin
      failures++;
      $display("FAIL handshake_timeout: WriteReady=%0b required 1 for word %h", wif.WriteReady, w);
    end
    @(posedge CLK);
    #1 wif.WriteValid = 1'b0;
  endtask

  // Word-level interpretation of the stream, independent of cycle timing
  task automatic runModel(input logic [31:0] w[$]);
    int          mode;
    int          idx;
    int          rem;
    logic [31:0] x;
    exp_t        e;
    mode   = 0;
    idx    = 0;
    rem    = 0;
    x      = '0;
    expErr = 1'b0;
    expQ.delete();
    foreach (w[k]) begin
      case (mode)
        0: if (w[k] == SYNC_WORD) begin mode = 1; expErr = 1'b0; end
        1: begin
          if (w[k] == DESYNC_WORD) mode = 0;
          else if (w[k][31:28] == 4'hA) begin
            idx  = int'(w[k][7:0]);
            rem  = int'(w[k][23:16]) + 1;
            x    = '0;
            mode = 2;
          end else begin
            expErr = 1'b1;
            mode   = 0;
          end
        end
        2: begin
          if (w[k] == DESYNC_WORD) mode = 0;
          else begin
            x = x ^ w[k];
            if (idx < MF) begin
              e.idx  = idx;
              e.data = w[k];
              expQ.push_back(e);
            end else expErr = 1'b1;
            idx++;
            rem--;
`ifdef FRAME_CHECKSUM_EN
            if (rem == 0) mode = 3;
`else
            if (rem == 0) mode = 1;
`endif
          end
        end
        default: begin
          if (w[k] != x) expErr = 1'b1;
          mode = 1;
        end
      endcase
    end
    expBusy = (mode != 0);
  endtask

  task automatic genRound();
    int          nb;
    int          start;
    int          n;
    bit          aborted;
    logic [31:0] d;
    logic [31:0] x;
    stimQ.delete();
    repeat ($urandom_range(0, 2)) stimQ.push_back({4'h3, 28'($urandom())});
    stimQ.push_back(SYNC_WORD);
    nb = $urandom_range(1, 3);
    for (int b = 0; b < nb; b++) begin
      if ($urandom_range(0, 7) == 0) begin
        stimQ.push_back({4'h5, 28'($urandom())});
        stimQ.push_back(SYNC_WORD);
      end else begin
        start   = $urandom_range(0, 34);
        n       = $urandom_range(1, 3);
        aborted = 1'b0;
        x       = '0;
        stimQ.push_back({4'hA, 4'h0, 8'(n - 1), 8'h00, 8'(start)});
        for (int k = 0; k < n; k++) begin
          if (k > 0 && $urandom_range(0, 5) == 0) begin
            stimQ.push_back(DESYNC_WORD);
            stimQ.push_back(SYNC_WORD);
            aborted = 1'b1;
            break;
          end
          d = $urandom();
          if (d == DESYNC_WORD) d = '0;
          stimQ.push_back(d);
          x = x ^ d;
        end
`ifdef FRAME_CHECKSUM_EN
        if (!aborted) stimQ.push_back(($urandom_range(0, 1) == 1) ? x : (x ^ 32'h1));
`endif
      end
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    wif.WriteValid = 1'b0;
    wif.WriteData  = '0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (FrameData !== '0) begin failures++; $display("FAIL reset_framedata: got %h required 0", FrameData); end
    checks++; if (FrameStrobe !== '0) begin failures++; $display("FAIL reset_strobe: got %h required 0", FrameStrobe); end
    checks++; if (Busy !== 1'b0 || Error !== 1'b0) begin failures++; $display("FAIL reset_flags: got busy=%b err=%b required 0 0", Busy, Error); end
    checks++; if (wif.WriteReady !== 1'b0) begin failures++; $display("FAIL reset_ready_low: got %b required 0", wif.WriteReady); end
    reset = 1'b0;
    @(posedge CLK);
    #1;
    checks++; if (wif.WriteReady !== 1'b1) begin failures++; $display("FAIL reset_ready_high: got %b required 1", wif.WriteReady); end
  endtask

  task automatic test_basic_frame();
    doReset();
    clearMon();
    sendWord(SYNC_WORD, 0);
    sendWord(32'hA000_0003, 0);
    sendWord(32'h1234_5678, 0);
    checks++; if (FrameData !== 32'h1234_5678) begin failures++; $display("FAIL basic_setup_data: got %h required 12345678", FrameData); end
    checks++; if (FrameStrobe !== '0) begin failures++; $display("FAIL basic_setup_strobe: got %h required 0", FrameStrobe); end
    for (int c = 0; c < SC; c++) begin
      @(posedge CLK);
      #1;
      checks++; if (FrameStrobe !== 32'h0000_0008) begin failures++; $display("FAIL basic_strobe_c%0d: got %h required 00000008", c, FrameStrobe); end
    end
    @(posedge CLK);
    #1;
    checks++; if (FrameStrobe !== '0 || FrameData !== 32'h1234_5678) begin failures++; $display("FAIL basic_hold: got strobe=%h data=%h required 0 12345678", FrameStrobe, FrameData); end
    checks++; if (Error !== 1'b0 || Busy !== 1'b1) begin failures++; $display("FAIL basic_flags: got err=%b busy=%b required 0 1", Error, Busy); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d[3];
    doReset();
    clearMon();
    sendWord(SYNC_WORD, 0);
    sendWord(32'hA002_001E, 0);
    for (int k = 0; k < 3; k++) begin
      d[k] = $urandom();
      if (d[k] == DESYNC_WORD) d[k] = '0;
      sendWord(d[k], 0);
    end
    repeat (8) @(posedge CLK);
    #1;
    checks++; if (evQ.size() !== 2) begin failures++; $display("FAIL oor_count: got %0d strobes required 2", evQ.size()); end
    checks++; if (evQ.size() < 2 || evQ[0].idx != 30 || evQ[0].data !== d[0]) begin failures++; $display("FAIL oor_first: got idx=%0d required 30 data %h", (evQ.size() > 0) ? evQ[0].idx : -1, d[0]); end
    checks++; if (evQ.size() < 2 || evQ[1].idx != 31 || evQ[1].data !== d[1]) begin failures++; $display("FAIL oor_second: got idx=%0d required 31 data %h", (evQ.size() > 1) ? evQ[1].idx : -1, d[1]); end
    checks++; if (Error !== 1'b1) begin failures++; $display("FAIL oor_error: got %b required 1", Error); end
  endtask

  task automatic test_bad_header();
    doReset();
    clearMon();
    sendWord(32'h1234_5678, 0);
    checks++; if (Busy !== 1'b0 || Error !== 1'b0) begin failures++; $display("FAIL hunt_ignore: got busy=%b err=%b required 0 0", Busy, Error); end
    sendWord(SYNC_WORD, 0);
    checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL sync_busy: got %b required 1", Busy); end
    sendWord(32'h5000_0000, 0);
    checks++; if (Error !== 1'b1 || Busy !== 1'b0) begin failures++; $display("FAIL bad_header: got err=%b busy=%b required 1 0", Error, Busy); end
    sendWord(SYNC_WORD, 0);
    checks++; if (Error !== 1'b0) begin failures++; $display("FAIL sync_clears_error: got %b required 0", Error); end
  endtask

  task automatic test_desync();
    logic [31:0] d;
    for (int r = 0; r < 3; r++) begin
      doReset();
      clearMon();
      d = $urandom();
      if (d == DESYNC_WORD) d = '0;
      sendWord(SYNC_WORD, $urandom_range(0, 3));
      sendWord(32'hA002_0005, $urandom_range(0, 3));
      sendWord(d, $urandom_range(0, 3));
      sendWord(DESYNC_WORD, $urandom_range(0, 3));
      repeat (8) @(posedge CLK);
      #1;
      checks++; if (evQ.size() != 1 || evQ[0].idx != 5) begin failures++; $display("FAIL desync_strobes: got %0d strobes required 1 at idx 5", evQ.size()); end
      checks++; if (Busy !== 1'b0 || FrameData !== d) begin failures++; $display("FAIL desync_state: got busy=%b data=%h required 0 %h", Busy, FrameData, d); end
      checks++; if (multiHot != 0 || jumps != 0) begin failures++; $display("FAIL desync_onehot: got multi=%0d jumps=%0d required 0 0", multiHot, jumps); end
    end
  endtask

  task automatic test_reset_mid_strobe();
    doReset();
    sendWord(SYNC_WORD, 0);
    sendWord(32'hA001_001F, 0);
    sendWord(32'h0000_1111, 0);
    sendWord(32'h0000_2222, 0);
    repeat (6) @(posedge CLK);
    sendWord(32'hA000_0002, 0);
    sendWord(32'hCAFE_0001, 0);
    @(posedge CLK);
    #1;
    checks++; if (FrameStrobe !== 32'h0000_0004 || Error !== 1'b1) begin failures++; $display("FAIL midreset_pre: got strobe=%h err=%b required 00000004 1", FrameStrobe, Error); end
    reset = 1'b1;
    @(posedge CLK);
    #1;
    checks++; if (FrameStrobe !== '0 || Busy !== 1'b0 || Error !== 1'b0) begin failures++; $display("FAIL midreset: got strobe=%h busy=%b err=%b required 0 0 0", FrameStrobe, Busy, Error); end
    reset = 1'b0;
    @(posedge CLK);
    #1;
    checks++; if (FrameStrobe !== '0) begin failures++; $display("FAIL midreset_after: got strobe=%h required 0", FrameStrobe); end
  endtask

  task automatic test_random();
    int m;
    for (int r = 0; r < 8; r++) begin
      doReset();
      clearMon();
      genRound();
      runModel(stimQ);
      foreach (stimQ[k]) sendWord(stimQ[k], $urandom_range(0, 3));
      repeat (12) @(posedge CLK);
      #1;
      checks++; if (evQ.size() != expQ.size()) begin failures++; $display("FAIL rnd%0d_count: got %0d strobes required %0d", r, evQ.size(), expQ.size()); end
      m = (evQ.size() < expQ.size()) ? evQ.size() : expQ.size();
      for (int i = 0; i < m; i++) begin
        checks++;
        if (evQ[i].idx != expQ[i].idx || evQ[i].data !== expQ[i].data[FB-1:0]) begin
          failures++;
          $display("FAIL rnd%0d_frame%0d: got idx=%0d data=%h required idx=%0d data=%h", r, i, evQ[i].idx, evQ[i].data, expQ[i].idx, expQ[i].data);
        end
        checks++;
        if (evQ[i].len != SC || !evQ[i].setupOk || !evQ[i].holdOk) begin
          failures++;
          $display("FAIL rnd%0d_timing%0d: got len=%0d setup=%b hold=%b required %0d 1 1", r, i, evQ[i].len, evQ[i].setupOk, evQ[i].holdOk, SC);
        end
      end
      checks++; if (multiHot != 0 || jumps != 0 || sameEdge != 0) begin failures++; $display("FAIL rnd%0d_invariants: got multi=%0d jumps=%0d same=%0d required 0 0 0", r, multiHot, jumps, sameEdge); end
      checks++; if (Error !== expErr || Busy !== expBusy) begin failures++; $display("FAIL rnd%0d_flags: got err=%b busy=%b required %b %b", r, Error, Busy, expErr, expBusy); end
    end
  endtask

`ifdef FRAME_CHECKSUM_EN
  task automatic test_checksum();
    doReset();
    sendWord(SYNC_WORD, 0);
    sendWord(32'hA001_0000, 0);
    sendWord(32'hFFFF_0000, 0);
    sendWord(32'h0F0F_0F0F, 0);
    sendWord(32'hF0F0_0F0F, 0);
    checks++; if (Error !== 1'b0 || Busy !== 1'b1) begin failures++; $display("FAIL checksum_good: got err=%b busy=%b required 0 1", Error, Busy); end
    sendWord(32'hA001_0000, 0);
    sendWord(32'hFFFF_0000, 0);
    sendWord(32'h0F0F_0F0F, 0);
    sendWord(32'h0000_0000, 0);
    checks++; if (Error !== 1'b1) begin failures++; $display("FAIL checksum_bad: got err=%b required 1", Error); end
  endtask
`endif

  initial begin
    wif.WriteValid = 1'b0;
    wif.WriteData  = '0;
    test_reset();
    test_basic_frame();
    test_out_of_range();
    test_bad_header();
    test_desync();
    test_reset_mid_strobe();
    test_random();
`ifdef FRAME_CHECKSUM_EN
    test_checksum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
